// File: rtl/booth_controller.sv
// Sequencing FSM for a radix-2 Booth multiplier.
// It drives load, clear, add, subtract and shift strobes to the multiplier
// datapath, counts WIDTH iterations, and pulses done for one cycle at the end.
// Every output is a flop loaded from a decode of the next state. This keeps the
// outputs Moore-style: there is no combinational path from start, q0 or qm1 to
// any output pin.
module booth_controller #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  output logic             ld_m,
  output logic             ld_q,
  output logic             clr_acc,
  output logic             add_en,
  output logic             sub_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_ARITH = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic ld_m_q, ld_m_d;
  logic ld_q_q, ld_q_d;
  logic clr_acc_q, clr_acc_d;
  logic add_en_q, add_en_d;
  logic sub_en_q, sub_en_d;
  logic shift_en_q, shift_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state, Booth-op and iteration-count logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        count_d = CNT_INIT;
        op_d    = OP_NONE;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // The Booth pair {Q[0], Q[-1]} is sampled only here.
        unique case ({q0, qm1})
          2'b01:   op_d = OP_ADD;
          2'b10:   op_d = OP_SUB;
          default: op_d = OP_NONE;
        endcase
        state_d = (op_d == OP_NONE) ? S_SHIFT : S_ARITH;
      end
      S_ARITH: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Saturate at zero. Treating count <= 1 as the last pass means a
        // corrupted count cannot hold the FSM in a loop forever.
        if (count_q != '0) count_d = count_q - CNT_ONE;
        state_d = (count_q <= CNT_ONE) ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        count_d = '0;
        op_d    = OP_NONE;
        state_d = S_IDLE;
      end
      default: begin
        count_d = '0;
        op_d    = OP_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  // Decode the strobes from the next state, so the flopped strobes line up with state_q.
  always_comb begin
    ld_m_d     = (state_d == S_INIT);
    ld_q_d     = (state_d == S_INIT);
    clr_acc_d  = (state_d == S_INIT);
    add_en_d   = (state_d == S_ARITH) && (op_d == OP_ADD);
    sub_en_d   = (state_d == S_ARITH) && (op_d == OP_SUB);
    shift_en_d = (state_d == S_SHIFT);
    busy_d     = (state_d == S_INIT) || (state_d == S_CHECK) ||
                 (state_d == S_ARITH) || (state_d == S_SHIFT);
    done_d     = (state_d == S_DONE);
  end

  // State, op, count and output registers. Reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NONE;
      count_q    <= '0;
      ld_m_q     <= 1'b0;
      ld_q_q     <= 1'b0;
      clr_acc_q  <= 1'b0;
      add_en_q   <= 1'b0;
      sub_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      count_q    <= count_d;
      ld_m_q     <= ld_m_d;
      ld_q_q     <= ld_q_d;
      clr_acc_q  <= clr_acc_d;
      add_en_q   <= add_en_d;
      sub_en_q   <= sub_en_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ld_m     = ld_m_q;
  assign ld_q     = ld_q_q;
  assign clr_acc  = clr_acc_q;
  assign add_en   = add_en_q;
  assign sub_en   = sub_en_q;
  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller.
// A small behavioural model of the multiplier datapath closes the q0/qm1 loop.
// The expected Booth ops, latency and product come straight from the operand bits
// and plain signed multiplication.
module tb_booth_controller;

  localparam int W  = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          q0, qm1;
  logic          ld_m, ld_q, clr_acc, add_en, sub_en, shift_en, busy, done;
  logic [CW-1:0] count;

  int n_chk  = 0;
  int n_fail = 0;

  booth_controller #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .qm1(qm1),
    .ld_m(ld_m), .ld_q(ld_q), .clr_acc(clr_acc), .add_en(add_en),
    .sub_en(sub_en), .shift_en(shift_en), .busy(busy), .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  // Datapath model: sign-extended accumulator, multiplier register and Q[-1]
  logic [W-1:0] m_in = '0, q_in = '0;
  logic [W:0]   m_reg = '0, acc = '0;
  logic [W-1:0] q_reg = '0;
  logic         qm1_reg = 1'b0;
  logic signed [2*W+1:0] cat;
  assign cat = {acc, q_reg, qm1_reg};
  assign q0  = q_reg[0];
  assign qm1 = qm1_reg;

  always @(posedge clk) begin
    if (ld_m)     m_reg <= {m_in[W-1], m_in};
    if (ld_q)     begin q_reg <= q_in; qm1_reg <= 1'b0; end
    if (clr_acc)  acc <= '0;
    if (add_en)   acc <= acc + m_reg;
    if (sub_en)   acc <= acc - m_reg;
    if (shift_en) {acc, q_reg, qm1_reg} <= cat >>> 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Invariants checked on every cycle outside reset
  always @(negedge clk) begin
    if (rst) begin
      check_eq("strobe_excl", 32'($countones({add_en, sub_en, shift_en}) <= 1), 32'd1);
      if (!busy && !done)
        check_eq("idle_quiet", {26'd0, ld_m, ld_q, clr_acc, add_en, sub_en, shift_en}, 32'd0);
    end
  end

  // Run one multiply and check the op sequence, count, latency, busy and product.
  task automatic run_op(input logic [W-1:0] mv, input logic [W-1:0] qv, input bit noise);
    int exp_ops[W];
    int n_arith = 0;
    int iter = 0, lat = 0, busy_n = 0, cur = 0;
    bit fin = 0;
    logic [2*W-1:0] prod;
    for (int i = 0; i < W; i++) begin
      logic b, bm;
      b  = qv[i];
      bm = (i == 0) ? 1'b0 : qv[i-1];
      exp_ops[i] = ({b, bm} == 2'b01) ? 1 : ({b, bm} == 2'b10) ? 2 : 0;
      if (exp_ops[i] != 0) n_arith++;
    end
    prod = $signed({{W{mv[W-1]}}, mv}) * $signed({{W{qv[W-1]}}, qv});
    m_in = mv;
    q_in = qv;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!fin && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check_eq("init_strobes", {28'd0, ld_m, ld_q, clr_acc, busy}, 32'hf);
      if (busy) busy_n++;
      if (add_en) cur = 1;
      if (sub_en) cur = 2;
      if (shift_en) begin
        if (iter < W) begin
          check_eq("op_seq", cur, exp_ops[iter]);
          check_eq("count_step", 32'(count), W - iter);
        end
        iter++;
        cur = 0;
      end
      if (done) begin
        fin = 1;
        start = 1'b0;
        check_eq("done_count", 32'(count), 32'd0);
        check_eq("product", 32'({acc[W-1:0], q_reg}), 32'(prod));
      end else if (noise) begin
        start = busy && ($urandom_range(0, 2) == 0);
      end
    end
    start = 1'b0;
    if (!fin) check_eq("done_timeout", 32'd0, 32'd1);
    check_eq("iterations", iter, W);
    check_eq("latency", lat, 2 + 2*W + n_arith);
    check_eq("busy_cycles", busy_n, 1 + 2*W + n_arith);
  endtask

  initial begin
    int dones, exp_dones, waited;
    bit found;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", {20'd0, ld_m, ld_q, clr_acc, add_en, sub_en, shift_en, busy, done, 1'b0, count}, 32'd0);
    rst = 1'b1;

    // Directed patterns from the operand corners
    run_op(6'($urandom), 6'b000010, 1'b0);
    run_op(6'($urandom), 6'b000000, 1'b0);
    run_op(6'($urandom), 6'b010101, 1'b0);
    run_op(6'b100000, 6'b100000, 1'b0);
    run_op(6'b011111, 6'b111111, 1'b0);

    // start held high: back-to-back operations, no queuing
    m_in = 6'($urandom);
    q_in = '0;
    @(posedge clk); #1 start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    exp_dones = 0;
    for (int k = 0; k < 10; k++)
      if (1 + (2 + 2*W) + k*(3 + 2*W) <= 40) exp_dones++;
    check_eq("held_start_dones", dones, exp_dones);
    waited = 0;
    while (!done && waited < 60) begin @(negedge clk); waited++; end
    check_eq("held_start_drain", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("no_queued_start", {30'd0, busy, done}, 32'd0);

    // Asynchronous reset in the middle of an operation
    m_in = 6'($urandom);
    q_in = 6'b000010;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    waited = 0;
    while (!found && waited < 40) begin
      @(negedge clk);
      waited++;
      if (sub_en) found = 1;
    end
    check_eq("saw_sub_en", 32'(found), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    #1 check_eq("async_reset", {20'd0, ld_m, ld_q, clr_acc, add_en, sub_en, shift_en, busy, done, 1'b0, count}, 32'd0);
    @(negedge clk) rst = 1'b1;
    run_op(6'($urandom), 6'($urandom), 1'b0);

    // Random operands, with stray start pulses while busy
    for (int r = 0; r < 20; r++)
      run_op(6'($urandom), 6'($urandom), 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
